exec_pipe: RTL and testbench
============================

EXEC_PIPE -- requirements
Module: exec_pipe

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands, result, pc and jump target.
REQ-002 Parameter MUL_LAT, default 4, cycles from MUL acceptance to out_valid (legal range 2..16).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream presents an operation.
REQ-006 in_ready  output  1  block accepts the operation this cycle.
REQ-007 op  input  4  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 MUL; 10-15 illegal.
REQ-008 src_imm  input  1  0: ALU B operand = R2; 1: B = imm_s.
REQ-009 jmp_sel  input  1  0: pc_jmp = pc_n + imm_s; 1: pc_jmp = R2.
REQ-010 R1, R2, imm_s, pc_n  input  WIDTH each  operands, sign-extended immediate, next pc.
REQ-011 out_valid  output  1  result, pc_jmp, wdata, err are valid.
REQ-012 out_ready  input  1  downstream consumes outputs this cycle.
REQ-013 result, pc_jmp, wdata  output  WIDTH each  registered ALU result, jump target, store data (= R2 at acceptance).
REQ-014 err  output  1  accepted op was illegal.
REQ-015 busy  output  1  high while a MUL is in progress.

Function
REQ-016 Handshake: transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 in_ready = (state == IDLE) && (!out_valid || out_ready); combinational, no dependence on in_valid.
REQ-018 States: IDLE, MUL_RUN; single output register (depth one).
REQ-019 IDLE, non-MUL accepted -> next cycle out_valid=1 with result; latency 1.
REQ-020 IDLE, MUL accepted -> MUL_RUN, counter loaded MUL_LAT-1, busy=1; counter decrements each cycle; at counter 1 -> IDLE, next cycle out_valid=1; total latency MUL_LAT.
REQ-021 Operands, src_imm, jmp_sel captured at acceptance; input changes during MUL_RUN have no effect.
REQ-022 While out_valid && !out_ready, all outputs hold stable and in_ready=0.
REQ-023 out_valid && out_ready with simultaneous non-MUL acceptance: out_valid stays 1, outputs update to new op next cycle (back-to-back, one per cycle).
REQ-024 out_valid && out_ready, no acceptance: out_valid=0 next cycle, data outputs hold last value.
REQ-025 MUL completing while a prior result is still held cannot occur: MUL accepted only when output slot is free or being drained.
REQ-026 ADD/SUB/MUL wrap modulo 2^WIDTH; MUL returns low WIDTH bits of unsigned product.
REQ-027 Shifts use B[clog2(WIDTH)-1:0] as amount; SRA replicates R1 MSB.
REQ-028 SLT: result = 1 if signed R1 < signed B else 0, zero-extended.
REQ-029 pc_jmp computed for every op, wraps modulo 2^WIDTH.
REQ-030 Illegal op: accepted normally, latency 1, result=0, err=1; err=0 for legal ops.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, counter 0, out_valid=0, busy=0, err=0, result/pc_jmp/wdata=0.
REQ-032 rst during MUL_RUN or with a held result: operation discarded, no out_valid afterward.
REQ-033 While rst=1, in_ready=0; first acceptance possible in cycle after rst deasserts.

Verification
REQ-034 ADD R1=0xFFFFFFFF, R2=2, src_imm=0, out_ready=1 -> one cycle later out_valid=1, result=0x00000001, wdata=2.
REQ-035 SUB src_imm=1, R1=5, imm_s=0xFFFFFFFE, jmp_sel=0, pc_n=0x100 -> result=7, pc_jmp=0x000000FE.
REQ-036 MUL R1=0x10000, R2=0x10001, MUL_LAT=4 -> in_ready=0, busy=1 for cycles 1-3, out_valid at cycle 4, result=0x00010000.
REQ-037 Two back-to-back ADDs with out_ready held 0 for 3 cycles -> first result stable 3 cycles, in_ready=0, second accepted in the out_ready=1 cycle, no loss or duplication.
REQ-038 SRA R1=0x80000000, imm_s=0x21, src_imm=1 -> result=0xC0000000 (amount 1); op=12 -> err=1, result=0.
REQ-039 rst asserted 2 cycles into a MUL -> out_valid=0, busy=0 next cycle; new ADD 1+1 after release -> result=2.

Source files
------------

// File: rtl/exec_pipe.sv
// Single-issue execute stage: one-cycle ALU ops, multi-cycle MUL, one-deep output register.
// Operands are captured at acceptance so upstream may change them while a MUL runs.
`timescale 1ns/1ps
module exec_pipe #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             src_imm,
  input  logic             jmp_sel,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  input  logic [WIDTH-1:0] imm_s,
  input  logic [WIDTH-1:0] pc_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] pc_jmp,
  output logic [WIDTH-1:0] wdata,
  output logic             err,
  output logic             busy
);

  localparam int SHW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = 5;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   pc_jmp_q, pc_jmp_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [WIDTH-1:0]   pend_pc_q, pend_pc_d;
  logic [WIDTH-1:0]   pend_wdata_q, pend_wdata_d;

  logic [WIDTH-1:0]   b_op;
  logic [WIDTH-1:0]   jmp_tgt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_err;
  logic [WIDTH-1:0]   mul_prod;
  logic [SHW-1:0]     shamt;
  logic               accept;

  assign b_op     = src_imm ? imm_s : R2;
  assign jmp_tgt  = jmp_sel ? R2 : (pc_n + imm_s);
  assign shamt    = b_op[SHW-1:0];
  assign mul_prod = mul_a_q * mul_b_q;

  // Slot is free, or is being drained this same cycle; never during reset.
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      4'd0: alu_res = R1 + b_op;
      4'd1: alu_res = R1 - b_op;
      4'd2: alu_res = R1 & b_op;
      4'd3: alu_res = R1 | b_op;
      4'd4: alu_res = R1 ^ b_op;
      4'd5: alu_res = R1 << shamt;
      4'd6: alu_res = R1 >> shamt;
      4'd7: alu_res = $unsigned($signed(R1) >>> shamt);
      4'd8: alu_res = {{(WIDTH-1){1'b0}}, ($signed(R1) < $signed(b_op))};
      4'd9: alu_res = '0;
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    pc_jmp_d     = pc_jmp_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    pend_pc_d    = pend_pc_q;
    pend_wdata_d = pend_wdata_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == 4'd9) begin
            state_d      = MUL_RUN;
            cnt_d        = CNT_W'(MUL_LAT - 1);
            mul_a_d      = R1;
            mul_b_d      = b_op;
            pend_pc_d    = jmp_tgt;
            pend_wdata_d = R2;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            pc_jmp_d    = jmp_tgt;
            wdata_d     = R2;
            err_d       = alu_err;
          end
        end
      end
      MUL_RUN: begin
        cnt_d = cnt_q - 1'b1;
        // Output slot is guaranteed empty here: a MUL only starts when it drains.
        if (cnt_q == CNT_W'(1)) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = mul_prod;
          pc_jmp_d    = pend_pc_q;
          wdata_d     = pend_wdata_q;
          err_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      pc_jmp_q     <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      pend_pc_q    <= '0;
      pend_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      pc_jmp_q     <= pc_jmp_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      pend_pc_q    <= pend_pc_d;
      pend_wdata_q <= pend_wdata_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign pc_jmp    = pc_jmp_q;
  assign wdata     = wdata_q;
  assign err       = err_q;
  assign busy      = (state_q == MUL_RUN);

endmodule

// File: tb/tb_exec_pipe.sv
// Scoreboard bench for exec_pipe: directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_exec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        src_imm;
  logic        jmp_sel;
  logic [31:0] R1, R2, imm_s, pc_n;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result, pc_jmp, wdata;
  logic        err;
  logic        busy;

  exec_pipe #(.WIDTH(32), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src_imm(src_imm), .jmp_sel(jmp_sel), .R1(R1), .R2(R2), .imm_s(imm_s),
    .pc_n(pc_n), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .pc_jmp(pc_jmp), .wdata(wdata), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] pc;
    logic [31:0] wd;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rand_rdy = 1'b0;
  int   n_out    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] r2,
                                 input logic [31:0] im, input logic [31:0] pcn,
                                 input logic si, input logic js);
    exp_t        e;
    logic [31:0] b;
    logic [63:0] p;
    int          s;
    b = si ? im : r2;
    s = int'(b % 32);
    e.er = 1'b0;
    e.res = 32'd0;
    case (o)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = a << s;
      4'd6: e.res = a >> s;
      4'd7: e.res = a[31] ? ~((~a) >> s) : (a >> s);
      4'd8: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9: begin
        p = {32'd0, a} * {32'd0, b};
        e.res = p[31:0];
      end
      default: e.er = 1'b1;
    endcase
    e.pc = js ? r2 : (pcn + im);
    e.wd = r2;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Presents one op and waits (bounded) for acceptance; returns at posedge+1 after the transfer.
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] r2,
                      input logic [31:0] im, input logic [31:0] pcn, input logic si, input logic js);
    bit got;
    got = 1'b0;
    op = o; R1 = a; R2 = r2; imm_s = im; pc_n = pcn; src_imm = si; jmp_sel = js;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(o, a, r2, im, pcn, si, js));
        got = 1'b1;
      end
      step();
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    R1 = $urandom; R2 = $urandom; imm_s = $urandom; op = 4'($urandom);
    src_imm = 1'($urandom); jmp_sel = 1'($urandom);
  endtask

  task automatic monitor();
    bit          held;
    logic [31:0] h_res, h_pc, h_wd;
    logic        h_er;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", result, h_res);
        chk("hold_pc_jmp", pc_jmp, h_pc);
        chk("hold_wdata", wdata, h_wd);
        chk("hold_err", 32'(err), 32'(h_er));
      end
      held = 1'b0;
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        held = 1'b1;
        h_res = result; h_pc = pc_jmp; h_wd = wdata; h_er = err;
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          n_out++;
          $display("OUT #%0d result=%h pc_jmp=%h wdata=%h err=%0d", n_out, result, pc_jmp, wdata, err);
          chk("sb_result", result, e.res);
          chk("sb_pc_jmp", pc_jmp, e.pc);
          chk("sb_wdata", wdata, e.wd);
          chk("sb_err", 32'(err), 32'(e.er));
        end
      end
    end
  endtask

  task automatic stimulus();
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; op = 4'd0; src_imm = 1'b0; jmp_sel = 1'b0;
    R1 = 32'd0; R2 = 32'd0; imm_s = 32'd0; pc_n = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_pc_jmp", pc_jmp, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    step();

    // ADD wrap
    send(4'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_result", result, 32'h0000_0001);
    chk("add_wdata", wdata, 32'd2);
    step();

    // SUB with immediate, pc-relative jump
    send(4'd1, 32'd5, 32'd9, 32'hFFFF_FFFE, 32'h100, 1'b1, 1'b0);
    @(negedge clk);
    chk("sub_result", result, 32'd7);
    chk("sub_pc_jmp", pc_jmp, 32'h0000_00FE);
    step();

    // MUL latency
    send(4'd9, 32'h0001_0000, 32'h0001_0001, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("mul_c%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("mul_c%0d_busy", c), 32'(busy), 32'd1);
      chk($sformatf("mul_c%0d_valid", c), 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("mul_valid", 32'(out_valid), 32'd1);
    chk("mul_busy_done", 32'(busy), 32'd0);
    chk("mul_result", result, 32'h0001_0000);
    chk("mul_pc_jmp", pc_jmp, 32'h0001_0001);
    step();

    // Back-pressure with a second op waiting
    out_ready = 1'b0;
    send(4'd0, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
    op = 4'd0; R1 = 32'd10; R2 = 32'd20; src_imm = 1'b0; jmp_sel = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'd7);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept", 32'(in_ready), 32'd1);
    sb.push_back(model(4'd0, 32'd10, 32'd20, imm_s, pc_n, 1'b0, 1'b0));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp2_valid", 32'(out_valid), 32'd1);
    chk("bp2_result", result, 32'd30);
    step();

    // SRA with oversized immediate amount, then an illegal op
    send(4'd7, 32'h8000_0000, 32'd0, 32'h21, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("sra_result", result, 32'hC000_0000);
    step();
    send(4'd12, 32'h1234_5678, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_result", result, 32'd0);
    step();

    // Reset in the middle of a MUL
    send(4'd9, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    sb.delete();
    step();
    @(negedge clk);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mrst_no_out", 32'(out_valid), 32'd0);
    end
    step();
    send(4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mrst_add_result", result, 32'd2);
    step();

    // Randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [3:0]  o;
      logic [31:0] a, b2, im;
      o  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      b2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      im = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      send(o, a, b2, im, $urandom, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && sb.size() != 0; k++) step();
    repeat (2) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
